// File: rtl/i2c_slave_target.sv
// I2C target: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address, moves bytes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample stability filter after each synchronizer.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_DATA, TX_DATA, GET_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, tx_sh;
  logic       rw;

  // Idle bus level is high, so reset the pipeline to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_cnt, sda_cnt;
  logic       scl_flt, sda_flt;

  // Level follows the synced input only after 3 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_flt <= 1'b1;
      sda_flt <= 1'b1;
    end else begin
      if (scl_sync[1] == scl_flt) scl_cnt <= '0;
      else if (scl_cnt == 2'd2) begin
        scl_flt <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 2'd1;
      if (sda_sync[1] == sda_flt) sda_cnt <= '0;
      else if (sda_cnt == 2'd2) begin
        sda_flt <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 2'd1;
    end
  end
  assign scl_f = scl_flt;
  assign sda_f = sda_flt;
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_sh     <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      nack_seen <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shreg[6:0] == SLAVE_ADDR) begin
                state  <= ACK_ADDR;
                rw     <= sda_f;
                tx_req <= sda_f;
              end else state <= WAIT_STOP;
            end
          end
          // bit_cnt 8: ACK not yet driven; 9: driving ACK, next fall ends the 9th clock.
          ACK_ADDR, ACK_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= 4'd9;
            end else if (state == ACK_ADDR && rw) begin
              state   <= TX_DATA;
              tx_sh   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 4'd1;
            end else begin
              state   <= RX_DATA;
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
            end
          end
          RX_DATA: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data  <= {shreg[6:0], sda_f};
              rx_valid <= 1'b1;
              state    <= ACK_DATA;
            end
          end
          TX_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              state   <= GET_ACK;
              bit_cnt <= '0;
            end else begin
              sda_oe  <= ~tx_sh[6];
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          GET_ACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                nack_seen <= 1'b1;
                state     <= WAIT_STOP;
              end else begin
                tx_req  <= 1'b1;
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              state   <= TX_DATA;
              tx_sh   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 4'd1;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bus-level controller model, random transactions, queue scoreboard.
module tb_i2c_slave_target;
  localparam int Q = 6;
  localparam logic [6:0] SLV = 7'h50;

  logic       clk = 1'b0;
  logic       rst_n, scl, sda_m;
  logic       sda_oe, rx_valid, tx_req, busy, nack_seen;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_target #(.SLAVE_ADDR(SLV)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data),
    .busy(busy), .nack_seen(nack_seen)
  );

  int errors = 0, checks = 0;
  int tx_req_cnt = 0, nack_cnt = 0, drive_viol = 0;
  int exp_txreq = 0, exp_nack = 0;
  bit no_drive = 1'b0;
  logic [7:0] rx_exp[$], tx_src[$], rd_exp[$], rd_got[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT or the controller model presents data.
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) begin
      chk("rx_expected", 32'(rx_exp.size() != 0), 32'd1);
      if (rx_exp.size() != 0) chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
    end
    if (tx_req) begin
      tx_req_cnt++;
      chk("tx_src_avail", 32'(tx_src.size() != 0), 32'd1);
      if (tx_src.size() != 0) tx_data = tx_src.pop_front();
    end
    if (nack_seen) nack_cnt++;
    if (rd_got.size() != 0) begin
      chk("rd_expected", 32'(rd_exp.size() != 0), 32'd1);
      if (rd_exp.size() != 0) chk("rd_byte", 32'(rd_got.pop_front()), 32'(rd_exp.pop_front()));
      else void'(rd_got.pop_front());
    end
    if (no_drive && sda_oe) drive_viol++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbit(input logic b);
    wait_clk(Q); sda_m = b; wait_clk(Q); scl = 1'b1; wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wait_clk(2*Q); scl = 1'b1; wait_clk(Q); b = sda_line; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack_n);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic bv;
    d = '0;
    for (int i = 7; i >= 0; i--) begin rbit(bv); d[i] = bv; end
    wbit(nack);
  endtask

  task automatic bus_start;
    if (!scl) begin wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl = 1'b1; end
    wait_clk(2*Q); sda_m = 1'b0; wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop;
    wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(2*Q); sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] d[4]);
    logic ack_n;
    bit   match = (a == SLV);
    int   v0 = drive_viol;
    bus_start;
    chk("busy_start", 32'(busy), 32'd1);
    no_drive = !match;
    wbyte({a, 1'b0}, ack_n);
    chk("addr_ack_w", 32'(ack_n), 32'(!match));
    for (int i = 0; i < n; i++) begin
      if (match) rx_exp.push_back(d[i]);
      wbyte(d[i], ack_n);
      chk("data_ack", 32'(ack_n), 32'(!match));
    end
    chk("busy_mid", 32'(busy), 32'd1);
    bus_stop;
    no_drive = 1'b0;
    chk("busy_stop", 32'(busy), 32'd0);
    chk("no_drive", 32'(drive_viol - v0), 32'd0);
    chk("rx_drained", 32'(rx_exp.size()), 32'd0);
  endtask

  task automatic do_read(input int n, input logic [7:0] d[4], input bit rep);
    logic       ack_n;
    logic [7:0] b;
    if (rep) begin
      bus_start;
      wbyte({SLV, 1'b0}, ack_n);
      chk("rep_wr_ack", 32'(ack_n), 32'd0);
    end
    bus_start;
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin tx_src.push_back(d[i]); rd_exp.push_back(d[i]); end
    exp_txreq += n;
    exp_nack  += 1;
    wbyte({SLV, 1'b1}, ack_n);
    chk("addr_ack_r", 32'(ack_n), 32'd0);
    for (int i = 0; i < n; i++) begin
      rbyte(b, i == n - 1);
      rd_got.push_back(b);
    end
    bus_stop;
    chk("busy_stop", 32'(busy), 32'd0);
    chk("tx_req_cnt", 32'(tx_req_cnt), 32'(exp_txreq));
    chk("nack_cnt", 32'(nack_cnt), 32'(exp_nack));
    chk("rd_drained", 32'(rd_exp.size()), 32'd0);
    chk("tx_drained", 32'(tx_src.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d[4];
    logic [7:0] b;
    logic       ack_n;
    logic [6:0] a;
    int         n, v0;
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_pulses", 32'({rx_valid, tx_req, nack_seen}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    do_write(SLV, 1, d);
    chk("rx_data_hold", 32'(rx_data), 32'h3C);
    d = '{8'h77, 8'h12, 8'h00, 8'h00};
    do_write(7'h51, 2, d);
    d = '{8'h96, 8'h5A, 8'h00, 8'h00};
    do_read(2, d, 1'b0);
    d = '{8'hC3, 8'h01, 8'h00, 8'h00};
    do_read(2, d, 1'b1);

    // Reset while the target drives a 0 data bit.
    bus_start;
    tx_src.push_back(8'h00);
    exp_txreq += 1;
    wbyte({SLV, 1'b1}, ack_n);
    chk("rst_addr_ack", 32'(ack_n), 32'd0);
    wait_clk(Q + 3);
    chk("tx_drive0", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rel", 32'(sda_oe), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    v0 = drive_viol;
    no_drive = 1'b1;
    rbyte(b, 1'b1);
    chk("post_rst_read", 32'(b), 32'hFF);
    wbyte({SLV, 1'b0}, ack_n);
    chk("post_rst_noack", 32'(ack_n), 32'd1);
    bus_stop;
    no_drive = 1'b0;
    chk("post_rst_drive", 32'(drive_viol - v0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_txreq", 32'(tx_req_cnt), 32'(exp_txreq));
    chk("post_rst_nack", 32'(nack_cnt), 32'(exp_nack));

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    wait_clk(10);
    sda_m = 1'b0; wait_clk(1); sda_m = 1'b1;
    wait_clk(20);
    chk("glitch_busy", 32'(busy), 32'd0);
`endif

    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: do_write(SLV, n, d);
        1: begin
          a = 7'($urandom_range(0, 127));
          if (a == SLV) a = 7'h00;
          do_write(a, n, d);
        end
        2: do_read(n, d, 1'b0);
        default: do_read(n, d, 1'b1);
      endcase
    end
    wait_clk(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
